// File: rtl/lfsr_generator.sv
// -----------------------------------------------------------------------------
// lfsr_generator
//
// Transmit-side pattern source for the 8-bit LFSR link. Emits the same
// sequence the lock checker tracks, either as a free-running stream of good
// words or as a scripted burst:
//   good_len good words, GAP_CYC valid-low cycles, bad_len corrupted words,
//   then a one-cycle done pulse.
//
// Ports
//   clk           system clock
//   reset         asynchronous active-low reset
//   i_soft_reset  synchronous abort; loads i_seed into the LFSR state
//   i_seed        seed value loaded on i_soft_reset
//   i_enable      free-run enable (honoured only while idle)
//   i_start       single-cycle burst start pulse (honoured only while idle)
//   i_good_len    number of good words in the burst, latched on start
//   i_bad_len     number of corrupted words in the burst, latched on start
//   o_LFSR        registered output word
//   o_valid       o_LFSR is meaningful this cycle
//   o_bad         current valid word is corrupted
//   o_busy        a scripted burst is in progress
//   o_done        one-cycle pulse at the end of a burst
// -----------------------------------------------------------------------------
module lfsr_generator #(
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned GAP_CYC = 2    // legal range 1..15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_soft_reset,
    input  logic [7:0]       i_seed,
    input  logic             i_enable,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_good_len,
    input  logic [LEN_W-1:0] i_bad_len,
    output logic [7:0]       o_LFSR,
    output logic             o_valid,
    output logic             o_bad,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned GAP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOOD,
        ST_GAP,
        ST_BAD,
        ST_DONE
    } fsm_t;

    fsm_t             r_fsm;
    logic [7:0]       r_state;      // LFSR state register
    logic [7:0]       r_word;
    logic             r_valid;
    logic             r_bad;
    logic             r_busy;
    logic             r_done;
    logic [LEN_W-1:0] r_word_cnt;   // words left in the current GOOD/BAD phase
    logic [LEN_W-1:0] r_bad_len;    // bad length held until the BAD phase
    logic [GAP_W-1:0] r_gap_cnt;    // valid-low cycles left in GAP

    logic [7:0]       w_next_state;

    // One LFSR step. The zero-detect term on the feedback splices the
    // all-zero state into the cycle so the period is the full 256 states.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic       fb;
        logic [7:0] n;
        fb   = s[7] ^ (s[6:0] == 7'd0);
        n[0] = fb;
        n[1] = s[0];
        n[2] = s[1] ^ fb;
        n[3] = s[2] ^ fb;
        n[4] = s[3];
        n[5] = s[4];
        n[6] = s[5];
        n[7] = s[6] ^ fb;
        return n;
    endfunction

    assign w_next_state = lfsr_step(r_state);

    // Burst sequencer, LFSR state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm      <= ST_IDLE;
            r_state    <= 8'h01;
            r_word     <= 8'h00;
            r_valid    <= 1'b0;
            r_bad      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_word_cnt <= '0;
            r_bad_len  <= '0;
            r_gap_cnt  <= '0;
        end else if (i_soft_reset) begin
            // Abort everything; a simultaneous start is dropped.
            r_fsm      <= ST_IDLE;
            r_state    <= i_seed;
            r_valid    <= 1'b0;
            r_bad      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_word_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_valid <= 1'b0;
            r_bad   <= 1'b0;
            r_done  <= 1'b0;

            case (r_fsm)
                ST_IDLE: begin
                    if (i_start) begin
                        r_busy     <= 1'b1;
                        r_word_cnt <= i_good_len;
                        r_bad_len  <= i_bad_len;
                        r_gap_cnt  <= GAP_W'(GAP_CYC);
                        r_fsm      <= (i_good_len != '0) ? ST_GOOD : ST_GAP;
                    end else begin
                        r_busy <= 1'b0;
                        if (i_enable) begin
                            r_valid <= 1'b1;
                            r_word  <= r_state;
                            r_state <= w_next_state;
                        end
                    end
                end

                ST_GOOD: begin
                    r_valid <= 1'b1;
                    r_word  <= r_state;
                    r_state <= w_next_state;
                    if (r_word_cnt == LEN_W'(1)) begin
                        r_gap_cnt <= GAP_W'(GAP_CYC);
                        r_fsm     <= ST_GAP;
                    end else begin
                        r_word_cnt <= r_word_cnt - LEN_W'(1);
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(1)) begin
                        if (r_bad_len != '0) begin
                            r_word_cnt <= r_bad_len;
                            r_fsm      <= ST_BAD;
                        end else begin
                            r_fsm <= ST_DONE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                ST_BAD: begin
                    // Corrupt bit 0 of the emitted word only; the state
                    // itself keeps advancing along the good sequence.
                    r_valid <= 1'b1;
                    r_bad   <= 1'b1;
                    r_word  <= r_state ^ 8'h01;
                    r_state <= w_next_state;
                    if (r_word_cnt == LEN_W'(1)) begin
                        r_fsm <= ST_DONE;
                    end else begin
                        r_word_cnt <= r_word_cnt - LEN_W'(1);
                    end
                end

                ST_DONE: begin
                    // o_busy stays high through this cycle and drops in IDLE.
                    r_done <= 1'b1;
                    r_fsm  <= ST_IDLE;
                end

                default: begin
                    r_busy <= 1'b0;
                    r_fsm  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_LFSR  = r_word;
    assign o_valid = r_valid;
    assign o_bad   = r_bad;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_lfsr_generator.sv
// -----------------------------------------------------------------------------
// tb_lfsr_generator
//
// Self-checking bench for lfsr_generator. A behavioural model turns every
// accepted start into a per-cycle timeline of expected outputs (a queue) and
// steps an 8-bit LFSR value whenever a word is emitted; a negedge process
// compares the DUT against it every cycle. Directed scenarios additionally
// pin hand-computed literal words and timings.
// -----------------------------------------------------------------------------
module tb_lfsr_generator;

    localparam int unsigned LEN_W   = 5;
    localparam int unsigned GAP_CYC = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_soft_reset;
    logic [7:0]       i_seed;
    logic             i_enable;
    logic             i_start;
    logic [LEN_W-1:0] i_good_len;
    logic [LEN_W-1:0] i_bad_len;
    logic [7:0]       o_LFSR;
    logic             o_valid;
    logic             o_bad;
    logic             o_busy;
    logic             o_done;

    int n_tests = 0;
    int n_fail  = 0;

    lfsr_generator #(.LEN_W(LEN_W), .GAP_CYC(GAP_CYC)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_soft_reset (i_soft_reset),
        .i_seed       (i_seed),
        .i_enable     (i_enable),
        .i_start      (i_start),
        .i_good_len   (i_good_len),
        .i_bad_len    (i_bad_len),
        .o_LFSR       (o_LFSR),
        .o_valid      (o_valid),
        .o_bad        (o_bad),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ (s[6:0] == 7'd0);
        return {s[6] ^ fb, s[5], s[4], s[3], s[2] ^ fb, s[1] ^ fb, s[0], fb};
    endfunction

    typedef struct packed {
        logic v;   // word emitted this cycle
        logic b;   // word is corrupted
        logic d;   // done pulse
    } ev_t;

    ev_t        tl[$];            // remaining timeline of the running burst
    logic [7:0] m_state = 8'h01;
    logic [7:0] m_word  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_bad   = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;

    always @(posedge clk or negedge reset) begin
        ev_t e;
        if (!reset) begin
            tl.delete();
            m_state = 8'h01; m_word = 8'h00;
            m_valid = 1'b0; m_bad = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else if (i_soft_reset) begin
            tl.delete();
            m_state = i_seed;
            m_valid = 1'b0; m_bad = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else if (tl.size() > 0) begin
            e = tl.pop_front();
            m_valid = e.v; m_bad = e.b; m_done = e.d; m_busy = 1'b1;
            if (e.v) begin
                m_word  = e.b ? (m_state ^ 8'h01) : m_state;
                m_state = lfsr_next(m_state);
            end
        end else if (i_start) begin
            for (int i = 0; i < int'(i_good_len); i++) tl.push_back('{1'b1, 1'b0, 1'b0});
            for (int i = 0; i < int'(GAP_CYC); i++)    tl.push_back('{1'b0, 1'b0, 1'b0});
            for (int i = 0; i < int'(i_bad_len); i++)  tl.push_back('{1'b1, 1'b1, 1'b0});
            tl.push_back('{1'b0, 1'b0, 1'b1});
            m_valid = 1'b0; m_bad = 1'b0; m_done = 1'b0; m_busy = 1'b1;
        end else begin
            m_busy = 1'b0; m_done = 1'b0; m_bad = 1'b0;
            m_valid = i_enable;
            if (i_enable) begin
                m_word  = m_state;
                m_state = lfsr_next(m_state);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_valid", 32'(o_valid), 32'(m_valid));
        chk("cyc_bad",   32'(o_bad),   32'(m_bad));
        chk("cyc_busy",  32'(o_busy),  32'(m_busy));
        chk("cyc_done",  32'(o_done),  32'(m_done));
        if (m_valid) chk("cyc_word", 32'(o_LFSR), 32'(m_word));
    end

    // ---------------- directed + random stimulus ----------------
    logic [7:0] exp_fr [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                8'h40, 8'h80, 8'h00, 8'h8D, 8'h97};
    logic [7:0] exp_bw [5]  = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h11};
    logic       exp_bb [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] got_w  [8];
    logic       got_b  [8];
    logic [255:0] seen;
    logic [7:0] w, w0, w1, w256;
    int nv, done_c, dups, busy_c, k, nrun;

    task automatic soft_reset(input logic [7:0] seed);
        i_soft_reset = 1'b1;
        i_seed       = seed;
        @(negedge clk);
        i_soft_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; i_soft_reset = 1'b0; i_seed = 8'h00; i_enable = 1'b0;
        i_start = 1'b0; i_good_len = '0; i_bad_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_word",  32'(o_LFSR),  32'h00);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_busy",  32'(o_busy),  32'h0);
        chk("rst_done",  32'(o_done),  32'h0);

        // Free-run from reset.
        reset = 1'b1; i_enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("fr_valid", 32'(o_valid), 32'h1);
            chk("fr_word",  32'(o_LFSR),  32'(exp_fr[i]));
            chk("fr_bad",   32'(o_bad),   32'h0);
        end
        i_enable = 1'b0;

        // Scripted burst 3 good / 2 bad from seed 01.
        soft_reset(8'h01);
        i_good_len = 5'd3; i_bad_len = 5'd2; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("burst_busy_start", 32'(o_busy), 32'h1);
        i_good_len = 5'd17; i_bad_len = 5'd9;
        nv = 0; done_c = 0; busy_c = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (o_valid && nv < 8) begin got_w[nv] = o_LFSR; got_b[nv] = o_bad; nv++; end
            if (o_done) done_c = c;
            if (o_busy) busy_c++;
        end
        chk("burst_nwords", 32'(nv), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("burst_word", 32'(got_w[i]), 32'(exp_bw[i]));
            chk("burst_bad",  32'(got_b[i]), 32'(exp_bb[i]));
        end
        chk("burst_done_cycle", 32'(done_c), 32'd8);
        chk("burst_busy_cycles", 32'(busy_c), 32'd8);

        // Zero-length burst: only the gap, no words, state untouched (20).
        i_good_len = '0; i_bad_len = '0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        nv = 0; done_c = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (o_done) done_c = c;
            if (o_valid) nv++;
        end
        chk("zero_nwords", 32'(nv), 32'd0);
        chk("zero_done_cycle", 32'(done_c), 32'(GAP_CYC + 1));
        i_enable = 1'b1;
        @(negedge clk);
        chk("zero_state_kept", 32'(o_LFSR), 32'h20);
        i_enable = 1'b0;

        // Seed 00: full period, all values distinct, wraps back to 00.
        soft_reset(8'h00);
        i_enable = 1'b1;
        seen = '0; dups = 0; w0 = 8'hAA; w1 = 8'hAA; w256 = 8'hAA;
        for (int i = 0; i <= 256; i++) begin
            @(negedge clk);
            w = o_LFSR;
            if (!o_valid) dups++;
            if (i == 0) w0 = w;
            if (i == 1) w1 = w;
            if (i == 256) w256 = w;
            else begin
                if (seen[w]) dups++;
                seen[w] = 1'b1;
            end
        end
        i_enable = 1'b0;
        chk("wrap_first", 32'(w0), 32'h00);
        chk("wrap_second", 32'(w1), 32'h8D);
        chk("wrap_257th", 32'(w256), 32'h00);
        chk("wrap_dups", 32'(dups), 32'd0);
        chk("wrap_all_seen", 32'(&seen), 32'h1);

        // Soft reset during BAD with a simultaneous start.
        soft_reset(8'h01);
        i_good_len = 5'd2; i_bad_len = 5'd4; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        k = 0;
        while (!o_bad && k < 20) begin @(negedge clk); k++; end
        chk("midbad_reached", 32'(o_bad), 32'h1);
        i_soft_reset = 1'b1; i_seed = 8'hFF; i_start = 1'b1;
        @(negedge clk);
        i_soft_reset = 1'b0; i_start = 1'b0;
        chk("midbad_valid", 32'(o_valid), 32'h0);
        chk("midbad_busy",  32'(o_busy),  32'h0);
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_valid || o_busy || o_done) nv++;
        end
        chk("midbad_quiet", 32'(nv), 32'd0);
        i_enable = 1'b1;
        @(negedge clk);
        chk("midbad_next_word", 32'(o_LFSR), 32'hFF);
        i_enable = 1'b0;

        // Randomised mix of bursts, free-run, stray starts and soft resets.
        for (int it = 0; it < 40; it++) begin
            i_good_len = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 6));
            i_bad_len  = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 6));
            i_enable   = 1'($urandom);
            i_start    = ($urandom_range(0, 3) != 0);
            i_seed     = 8'($urandom);
            i_soft_reset = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            i_start = 1'b0; i_soft_reset = 1'b0;
            nrun = $urandom_range(2, 40);
            repeat (nrun) begin
                i_start      = ($urandom_range(0, 7) == 0);
                i_good_len   = LEN_W'($urandom);
                i_bad_len    = LEN_W'($urandom);
                i_enable     = 1'($urandom);
                i_soft_reset = ($urandom_range(0, 63) == 0);
                i_seed       = 8'($urandom);
                @(negedge clk);
            end
            i_start = 1'b0; i_soft_reset = 1'b0; i_enable = 1'b0;
        end

        // Async reset in the middle of GOOD.
        soft_reset(8'h5A);
        i_good_len = 5'd10; i_bad_len = 5'd1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("areset_in_good", 32'(o_valid), 32'h1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("areset_word",  32'(o_LFSR),  32'h00);
        chk("areset_valid", 32'(o_valid), 32'h0);
        chk("areset_busy",  32'(o_busy),  32'h0);
        chk("areset_done",  32'(o_done),  32'h0);
        @(negedge clk);
        reset = 1'b1; i_enable = 1'b1;
        @(negedge clk);
        chk("areset_first_word", 32'(o_LFSR), 32'h01);
        chk("areset_first_valid", 32'(o_valid), 32'h1);
        i_enable = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
